step_sequencer_mt: RTL

Parametrised multi-track step sequencer for the audio path. It runs its own beat/step counters from an external beat tick and plays a programmable pattern memory of note indices, one per track per step. Per-step enable switches gate the tones, and a one-hot LED shows the playhead. Tone outputs feed the existing PWM note generators; the beat tick comes from the shared tempo divider.

---
 rtl/step_sequencer_mt.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/step_sequencer_mt.sv
// step_sequencer_mt: multi-track step sequencer with a note pattern memory.
// Define STEP_GATE_EN to mute each step's final beat for articulation.
// Ports: clk, rst (async, active high); beat_tick tempo pulse;
//   start/stop/pause control pulses; loop level; last_step (sampled on
//   start); step_en live per-step gates (bit STEPS-1-s gates step s);
//   wr_en/wr_track/wr_step/wr_note pattern write; tone_out packed tones;
//   toneL/toneR first/last track; led one-hot playhead; step_idx; busy;
//   done one-cycle completion pulse.
module step_sequencer_mt #(
  parameter int STEPS          = 16,
  parameter int TRACKS         = 2,
  parameter int BEATS_PER_STEP = 4,
  parameter int TONE_W         = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        beat_tick,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        pause,
  input  logic                        loop,
  input  logic [$clog2(STEPS)-1:0]    last_step,
  input  logic [STEPS-1:0]            step_en,
  input  logic                        wr_en,
  input  logic [((TRACKS > 1) ? $clog2(TRACKS) : 1)-1:0] wr_track,
  input  logic [$clog2(STEPS)-1:0]    wr_step,
  input  logic [4:0]                  wr_note,
  output logic [TRACKS*TONE_W-1:0]    tone_out,
  output logic [TONE_W-1:0]           toneL,
  output logic [TONE_W-1:0]           toneR,
  output logic [STEPS-1:0]            led,
  output logic [$clog2(STEPS)-1:0]    step_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int SW = $clog2(STEPS);
  localparam int TW = (TRACKS > 1) ? $clog2(TRACKS) : 1;
  localparam int BW = (BEATS_PER_STEP > 1) ? $clog2(BEATS_PER_STEP) : 1;
  localparam logic [TONE_W-1:0] SIL = TONE_W'(100_000_000);
  localparam logic [STEPS-1:0] LED_MSB = {1'b1, {(STEPS-1){1'b0}}};
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS_PER_STEP - 1);

  typedef enum logic [1:0] {IDLE, PLAY, HOLD, DONE} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   step_q, step_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [SW-1:0]   last_q, last_d, last_cap;
  logic            done_q, done_d;
  logic [STEPS-1:0] led_q, led_d;
  logic [TONE_W-1:0] tone_q [TRACKS];
  logic [4:0]      pat [TRACKS][STEPS];
  logic            wr_ok;
  logic            gate;
  logic            sound;

  function automatic logic [TONE_W-1:0] note_freq(input logic [4:0] n);
    case (n)
      5'd1:    note_freq = TONE_W'(130);
      5'd2:    note_freq = TONE_W'(147);
      5'd3:    note_freq = TONE_W'(165);
      5'd4:    note_freq = TONE_W'(175);
      5'd5:    note_freq = TONE_W'(196);
      5'd6:    note_freq = TONE_W'(220);
      5'd7:    note_freq = TONE_W'(247);
      5'd8:    note_freq = TONE_W'(262);
      5'd9:    note_freq = TONE_W'(294);
      5'd10:   note_freq = TONE_W'(330);
      5'd11:   note_freq = TONE_W'(349);
      5'd12:   note_freq = TONE_W'(392);
      5'd13:   note_freq = TONE_W'(440);
      5'd14:   note_freq = TONE_W'(494);
      5'd15:   note_freq = TONE_W'(524);
      5'd16:   note_freq = TONE_W'(588);
      5'd17:   note_freq = TONE_W'(660);
      5'd18:   note_freq = TONE_W'(698);
      5'd19:   note_freq = TONE_W'(784);
      5'd20:   note_freq = TONE_W'(880);
      5'd21:   note_freq = TONE_W'(988);
      5'd22:   note_freq = TONE_W'(311);
      default: note_freq = SIL;
    endcase
  endfunction

  // Range checks only exist when the index width can exceed the range.
  generate
    if (TRACKS == (1 << TW)) begin : g_trk_full
      assign wr_ok = 1'b1;
    end else begin : g_trk_chk
      assign wr_ok = (32'(wr_track) < TRACKS);
    end
    if (STEPS == (1 << SW)) begin : g_last_full
      assign last_cap = last_step;
    end else begin : g_last_clamp
      assign last_cap = (32'(last_step) > STEPS - 1) ?
                        SW'(STEPS - 1) : last_step;
    end
  endgenerate

`ifdef STEP_GATE_EN
  assign gate = (BEATS_PER_STEP > 1) && (beat_q == BEAT_LAST);
`else
  assign gate = 1'b0;
`endif

  assign sound = (state_q == PLAY) && !gate &&
                 (|(step_en & (LED_MSB >> step_q)));

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    beat_d  = beat_q;
    last_d  = last_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      step_d  = '0;
      beat_d  = '0;
    end else if (start) begin
      state_d = PLAY;
      step_d  = '0;
      beat_d  = '0;
      last_d  = last_cap;
    end else if (pause) begin
      if (state_q == PLAY)
        state_d = HOLD;
      else if (state_q == HOLD)
        state_d = PLAY;
    end else if (beat_tick && state_q == PLAY) begin
      if (beat_q != BEAT_LAST) begin
        beat_d = beat_q + 1'b1;
      end else begin
        beat_d = '0;
        if (step_q < last_q) begin
          step_d = step_q + 1'b1;
        end else if (loop) begin
          step_d = '0;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    led_d = LED_MSB >> step_q;
    case (state_q)
      IDLE:    led_d = LED_MSB;
      DONE:    led_d = '1;
      default: led_d = LED_MSB >> step_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      beat_q  <= '0;
      last_q  <= SW'(STEPS - 1);
      done_q  <= 1'b0;
      led_q   <= LED_MSB;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      done_q  <= done_d;
      led_q   <= led_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < TRACKS; t++) begin
        tone_q[t] <= SIL;
        for (int s = 0; s < STEPS; s++)
          pat[t][s] <= '0;
      end
    end else begin
      for (int t = 0; t < TRACKS; t++)
        tone_q[t] <= sound ? note_freq(pat[t][step_q]) : SIL;
      if (wr_en && wr_ok)
        pat[wr_track][wr_step] <= wr_note;
    end
  end

  generate
    for (genvar t = 0; t < TRACKS; t++) begin : g_out
      assign tone_out[t*TONE_W +: TONE_W] = tone_q[t];
    end
  endgenerate

  assign toneL    = tone_q[0];
  assign toneR    = tone_q[TRACKS-1];
  assign led      = led_q;
  assign step_idx = step_q;
  assign busy     = (state_q == PLAY) || (state_q == HOLD);
  assign done     = done_q;

endmodule
